mips_dmem: RTL and testbench

// - Parametrised data memory for the MIPS datapath; successor to the plain word RAM.
// - Adds byte/halfword/word access with byte-lane stores and sign/zero-extended loads.
// - Adds a valid/ready request and response handshake with configurable wait states.
// - Sits between the MEM stage and the on-chip data array.

---
 rtl/mips_dmem_pkg.sv | 17 +
 rtl/mips_dmem_lane_fmt.sv | 50 +++++
 rtl/mips_dmem.sv | 178 +++++++++++++++++
 tb/tb_mips_dmem.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_dmem_pkg.sv
// Shared types and constants for the MIPS data memory.
// Used by mips_dmem and mips_dmem_lane_fmt.
package mips_dmem_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/mips_dmem_lane_fmt.sv
// Byte-lane formatting for data memory accesses.
// Store side builds lane mask/data; load side extracts and extends.
module mips_dmem_lane_fmt
  import mips_dmem_pkg::*;
(
  input  logic [1:0]        st_size,
  input  logic [1:0]        st_lo,
  input  logic [WORD_W-1:0] st_wdata,
  output logic [3:0]        st_be,
  output logic [WORD_W-1:0] st_data,
  input  logic [1:0]        ld_size,
  input  logic              ld_uns,
  input  logic [1:0]        ld_lo,
  input  logic [WORD_W-1:0] ld_word,
  output logic [WORD_W-1:0] ld_data
);

  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  // Store: replicate right-justified data into every lane, mask picks one.
  always_comb begin
    st_be   = 4'hF;
    st_data = st_wdata;
    case (st_size)
      SZ_BYTE: begin
        st_be   = 4'b0001 << st_lo;
        st_data = {4{st_wdata[7:0]}};
      end
      SZ_HALF: begin
        st_be   = st_lo[1] ? 4'b1100 : 4'b0011;
        st_data = {2{st_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load: little-endian lane pick, then sign or zero extension.
  always_comb begin
    ld_b    = ld_word[{ld_lo, 3'b000} +: 8];
    ld_h    = ld_lo[1] ? ld_word[31:16] : ld_word[15:0];
    ld_data = ld_word;
    case (ld_size)
      SZ_BYTE: ld_data = {{24{ld_b[7] & ~ld_uns}}, ld_b};
      SZ_HALF: ld_data = {{16{ld_h[15] & ~ld_uns}}, ld_h};
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_dmem.sv
// MIPS data memory with byte/half/word access and wait-state handshake.
// Optional macro DMEM_ALIGN_CHECK_EN enables misalignment/size faults.
module mips_dmem
  import mips_dmem_pkg::*;
#(
  parameter int    DEPTH_LOG2  = 10,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_uns,
  input  logic [31:0]       addr,
  input  logic [WORD_W-1:0] wdata,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rdata,
  output logic              rsp_err
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_LAST = 4'(WAIT_STATES - 1);

  logic [WORD_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic [1:0]        p_size_q, p_size_d;
  logic              p_uns_q, p_uns_d;
  logic [1:0]        p_lo_q, p_lo_d;
  logic [WORD_W-1:0] p_word_q, p_word_d;
  logic              p_zero_q, p_zero_d;

  logic [DEPTH_LOG2-1:0] idx;
  logic                  accept;
  logic                  fault;
  logic                  unused_addr;
  logic [3:0]            st_be;
  logic [WORD_W-1:0]     st_data;
  logic [1:0]            ld_size;
  logic                  ld_uns;
  logic [1:0]            ld_lo;
  logic [WORD_W-1:0]     ld_word;
  logic [WORD_W-1:0]     ld_data;
  logic                  ld_zero;

  assign idx         = addr[DEPTH_LOG2+1:2];
  assign unused_addr = ^addr[31:DEPTH_LOG2+2];
  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign accept      = req_valid & req_ready & ~rst;
  assign rdata       = rdata_q;

`ifdef DMEM_ALIGN_CHECK_EN
  logic rsp_err_q, rsp_err_d;
  logic p_err_q, p_err_d;

  assign fault = (req_size == 2'b11)
               | ((req_size == SZ_HALF) & addr[0])
               | ((req_size == SZ_WORD) & (|addr[1:0]));
  assign rsp_err = rsp_err_q;

  // Fault flag travels with the pending access into the response.
  always_comb begin
    p_err_d   = p_err_q;
    rsp_err_d = rsp_err_q;
    if (accept) p_err_d = fault;
    if (state_d == RESP && state_q != RESP)
      rsp_err_d = accept ? fault : p_err_q;
  end

  // Fault flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_err_q   <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      p_err_q   <= p_err_d;
      rsp_err_q <= rsp_err_d;
    end
  end
`else
  assign fault   = 1'b0;
  assign rsp_err = 1'b0;
`endif

  mips_dmem_lane_fmt u_fmt (
    .st_size  (req_size),
    .st_lo    (addr[1:0]),
    .st_wdata (wdata),
    .st_be    (st_be),
    .st_data  (st_data),
    .ld_size  (ld_size),
    .ld_uns   (ld_uns),
    .ld_lo    (ld_lo),
    .ld_word  (ld_word),
    .ld_data  (ld_data)
  );

  // Zero-wait accepts format straight from the array, else from the latch.
  always_comb begin
    ld_size = accept ? req_size  : p_size_q;
    ld_uns  = accept ? req_uns   : p_uns_q;
    ld_lo   = accept ? addr[1:0] : p_lo_q;
    ld_word = accept ? mem[idx]  : p_word_q;
    ld_zero = accept ? (req_write | fault) : p_zero_q;
  end

  // Next state, wait counter, pending latch and response data.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    p_size_d = p_size_q;
    p_uns_d  = p_uns_q;
    p_lo_d   = p_lo_q;
    p_word_d = p_word_q;
    p_zero_d = p_zero_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          p_size_d = req_size;
          p_uns_d  = req_uns;
          p_lo_d   = addr[1:0];
          p_word_d = mem[idx];
          p_zero_d = req_write | fault;
          cnt_d    = 4'd0;
          state_d  = (WAIT_STATES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) state_d = RESP;
        else                   cnt_d   = cnt_q + 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == RESP && state_q != RESP)
      rdata_d = ld_zero ? '0 : ld_data;
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      rdata_q  <= '0;
      p_size_q <= SZ_BYTE;
      p_uns_q  <= 1'b0;
      p_lo_q   <= 2'b00;
      p_word_q <= '0;
      p_zero_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      p_size_q <= p_size_d;
      p_uns_q  <= p_uns_d;
      p_lo_q   <= p_lo_d;
      p_word_q <= p_word_d;
      p_zero_q <= p_zero_d;
    end
  end

  // Byte-lane store commit on the accept edge; array is never reset.
  always_ff @(posedge clk) begin
    if (accept && req_write && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) mem[idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mips_dmem.sv
// Randomized scoreboard bench for mips_dmem.
// Byte-array reference model; monitor checks data, error and latency.
module tb_mips_dmem;

  localparam int DL        = 4;
  localparam int WS        = 3;
  localparam int MEM_BYTES = 4 << DL;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_uns = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        rsp_err;

  mips_dmem #(.DEPTH_LOG2(DL), .WAIT_STATES(WS)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_size  (req_size),
    .req_uns   (req_uns),
    .addr      (addr),
    .wdata     (wdata),
    .rsp_valid (rsp_valid),
    .rdata     (rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mb [MEM_BYTES];
  int          cyc = 0;
  int          vectors = 0;
  int          fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: byte-addressed memory, aligned base, plain arithmetic extension.
  function automatic void model_access(input bit wr, input logic [1:0] sz,
                                       input bit uns, input logic [31:0] a,
                                       input logic [31:0] wd,
                                       output logic [31:0] rd,
                                       output logic err);
    int n;
    int base;
    logic [31:0] v;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    err = (sz == 2'd3) || ((a % n) != 0);
`endif
    base = int'((a - (a % n)) % MEM_BYTES);
    rd = '0;
    if (err) return;
    if (wr) begin
      for (int i = 0; i < n; i++) mb[base + i] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(mb[base + i]) << (8 * i));
      if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      rd = v;
    end
  endfunction

  task automatic wait_ready(output bit ok);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = req_ready;
    if (!ok) begin
      vectors++;
      fails++;
      $display("FAIL ready_timeout: req_ready=%b want 1", req_ready);
    end
  endtask

  task automatic issue(input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input bit fx, input logic [31:0] xrd, input logic xerr);
    bit ok;
    exp_t e;
    logic [31:0] mrd;
    logic merr;
    wait_ready(ok);
    if (!ok) return;
    req_valid = 1'b1;
    req_write = wr;
    req_size  = sz;
    req_uns   = uns;
    addr      = a;
    wdata     = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    model_access(wr, sz, uns, a, wd, mrd, merr);
    e.rd  = fx ? xrd : mrd;
    e.err = fx ? xerr : merr;
    e.cyc = cyc;
    sb.push_back(e);
  endtask

  // Accepted but never answered: used for the mid-operation reset.
  task automatic issue_raw(input bit wr, input logic [31:0] a, input logic [31:0] wd);
    bit ok;
    logic [31:0] mrd;
    logic merr;
    wait_ready(ok);
    if (!ok) return;
    req_valid = 1'b1;
    req_write = wr;
    req_size  = 2'd2;
    req_uns   = 1'b0;
    addr      = a;
    wdata     = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    model_access(wr, 2'd2, 1'b0, a, wd, mrd, merr);
  endtask

  // Monitor: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid) begin
      vectors++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_rsp: rdata=%h err=%b with empty queue", rdata, rsp_err);
      end else begin
        e = sb.pop_front();
        if (rdata !== e.rd || rsp_err !== e.err || (cyc - e.cyc) != WS) begin
          fails++;
          $display("FAIL rsp: rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=%0d",
                   rdata, rsp_err, cyc - e.cyc, e.rd, e.err, WS);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  initial begin
    logic [31:0] r;
    logic [1:0]  sz;
    int n;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_ready", 32'(req_ready), 32'd1);
    check("reset_valid", 32'(rsp_valid), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_err", 32'(rsp_err), 32'd0);

    for (int i = 0; i < MEM_BYTES / 4; i++)
      issue(1'b1, 2'd2, 1'b0, 32'(4 * i), $urandom, 1'b0, '0, 1'b0);

    issue(1'b1, 2'd2, 1'b0, 32'h40, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0);
    issue(1'b1, 2'd0, 1'b0, 32'h41, 32'h1234_5680, 1'b1, 32'h0, 1'b0);
    issue(1'b0, 2'd0, 1'b0, 32'h41, 32'h0,         1'b1, 32'hFFFF_FF80, 1'b0);
    issue(1'b0, 2'd0, 1'b1, 32'h41, 32'h0,         1'b1, 32'h0000_0080, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0,         1'b1, 32'hDEAD_80EF, 1'b0);
`ifdef DMEM_ALIGN_CHECK_EN
    issue(1'b1, 2'd2, 1'b0, 32'h42, 32'h1234_5678, 1'b1, 32'h0, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0,         1'b1, 32'hDEAD_80EF, 1'b0);
`else
    issue(1'b1, 2'd2, 1'b0, 32'h42, 32'h1234_5678, 1'b1, 32'h0, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0,         1'b1, 32'h1234_5678, 1'b0);
`endif
    issue(1'b1, 2'd2, 1'b0, 32'h00, 32'hCAFE_F00D, 1'b1, 32'h0, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0,         1'b1, 32'hCAFE_F00D, 1'b0);
    issue(1'b0, 2'd1, 1'b0, 32'h02, 32'h0,         1'b1, 32'hFFFF_CAFE, 1'b0);
    issue(1'b0, 2'd1, 1'b1, 32'h00, 32'h0,         1'b1, 32'h0000_F00D, 1'b0);

    for (int i = 0; i < 300; i++) begin
      sz = 2'($urandom_range(0, 3));
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
            $urandom, $urandom, 1'b0, '0, 1'b0);
    end

    issue(1'b1, 2'd2, 1'b0, 32'h08, 32'h0BAD_C0DE, 1'b1, 32'h0, 1'b0);
    issue_raw(1'b1, 32'h0C, 32'h55AA_55AA);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    check("rst_mid_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    repeat (WS + 3) @(negedge clk);
    issue(1'b0, 2'd2, 1'b0, 32'h08, 32'h0, 1'b1, 32'h0BAD_C0DE, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, 1'b1, 32'h55AA_55AA, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h4C, 32'h0, 1'b0, '0, 1'b0);

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    r = 32'(sb.size());
    check("drain", r, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
